// File: rtl/sent_rx_arb_pkg.sv
// rtl/sent_rx_arb_pkg.sv - shared record layout and constants for the SENT receive frame arbiter
package sent_rx_arb_pkg;

    localparam int   PAYLOAD_W   = 24;
    localparam logic KIND_FAST   = 1'b0;
    localparam logic KIND_SERIAL = 1'b1;
    localparam int   DROP_W      = 8;

    // One buffered record: kind bit on top of the 24-bit payload.
    typedef struct packed {
        logic                 kind;
        logic [PAYLOAD_W-1:0] payload;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    // Drop counters stick at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/sent_rx_ch_fifo.sv
// rtl/sent_rx_ch_fifo.sv - single-clock per-channel record FIFO
module sent_rx_ch_fifo
    import sent_rx_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  rec_t wdata_i,
    output rec_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    rec_t           mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           do_pop;
    logic           do_push;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on an empty FIFO is ignored, so a same-cycle push into an empty FIFO is simply stored.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sent_rx_frame_arbiter.sv
// rtl/sent_rx_frame_arbiter.sv - round-robin readout of buffered SENT channel records
module sent_rx_frame_arbiter
    import sent_rx_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DEPTH = 2,
    parameter int CH_W  = 2
) (
    input  logic                     clk_rx,
    input  logic                     reset_rx,
    input  logic [N_CH-1:0]          ch_enable_i,
    input  logic [N_CH-1:0]          ch_wr_i,
    input  logic [N_CH-1:0]          ch_kind_i,
    input  logic [N_CH*PAYLOAD_W-1:0] ch_payload_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CH_W-1:0]          out_ch_o,
    output logic                     out_kind_o,
    output logic [PAYLOAD_W-1:0]     out_payload_o,
    output logic [N_CH-1:0]          ovf_o,
    input  logic [N_CH-1:0]          ovf_clr_i,
    output logic [N_CH*DROP_W-1:0]   drop_cnt_o
);

    logic [N_CH-1:0] push;
    logic [N_CH-1:0] push_acc;
    logic [N_CH-1:0] pop;
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] drop;
    rec_t            rdata [N_CH];

    logic            load_en;
    logic            any_ne;
    logic [CH_W-1:0] grant;
    rec_t            grant_rec;

    logic            out_valid_q;
    logic [CH_W-1:0] out_ch_q;
    rec_t            out_rec_q;
    logic [CH_W-1:0] last_q;

    logic [N_CH-1:0] ovf_q;
    logic [DROP_W-1:0] drop_q [N_CH];

    // The output register may take a new record when empty or when its record is being accepted.
    assign load_en = !out_valid_q || out_ready_i;

    // Disabled channels are ignored outright: no store, no drop accounting.
    assign push     = ch_wr_i & ch_enable_i;
    assign drop     = push & full & ~pop;
    assign push_acc = push & ~drop;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        any_ne    = 1'b0;
        grant     = '0;
        grant_rec = '0;
        for (int i = 1; i <= N_CH; i++) begin
            int idx;
            idx = int'(last_q) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (!any_ne && (c == idx) && !empty[c]) begin
                    any_ne    = 1'b1;
                    grant     = CH_W'(c);
                    grant_rec = rdata[c];
                end
            end
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < N_CH; gc++) begin : g_ch
            assign pop[gc] = load_en && any_ne && (grant == CH_W'(gc));

            sent_rx_ch_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk_i   (clk_rx),
                .rst_i   (reset_rx),
                .push_i  (push_acc[gc]),
                .pop_i   (pop[gc]),
                .wdata_i ({ch_kind_i[gc], ch_payload_i[PAYLOAD_W*gc +: PAYLOAD_W]}),
                .rdata_o (rdata[gc]),
                .full_o  (full[gc]),
                .empty_o (empty[gc])
            );

            // Sticky overflow flag and saturating drop count; a drop beats a same-cycle clear.
            always_ff @(posedge clk_rx) begin
                if (reset_rx) begin
                    ovf_q[gc]  <= 1'b0;
                    drop_q[gc] <= '0;
                end else if (drop[gc]) begin
                    ovf_q[gc]  <= 1'b1;
                    drop_q[gc] <= ovf_clr_i[gc] ? DROP_W'(1) : sat_inc(drop_q[gc]);
                end else if (ovf_clr_i[gc]) begin
                    ovf_q[gc]  <= 1'b0;
                    drop_q[gc] <= '0;
                end
            end

            assign drop_cnt_o[DROP_W*gc +: DROP_W] = drop_q[gc];
        end
    endgenerate

    // Output register and arbiter pointer; a stalled record is held untouched.
    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_rec_q   <= '0;
            last_q      <= CH_W'(N_CH - 1);
        end else if (load_en) begin
            if (any_ne) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= grant;
                out_rec_q   <= grant_rec;
                last_q      <= grant;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_ch_o      = out_ch_q;
    assign out_kind_o    = out_rec_q.kind;
    assign out_payload_o = out_rec_q.payload;
    assign ovf_o         = ovf_q;

endmodule

// File: doc/sent_rx_frame_arbiter.md
Name: sent_rx_frame_arbiter

Overview:
- Shares one host readout path between N_CH independent SENT receive channels, each a full receive chain.
- Each channel posts decoded records: fast-channel nibble data, or completed serial messages carrying ID plus data.
- The block buffers records per channel in small FIFOs and grants the output register round-robin.
- Output uses a valid/ready handshake and tags each record with its source channel; per-channel overflow status and drop counters are kept.

Parameters:
- N_CH, 4, number of SENT receive channels (2..8).
- DEPTH, 2, per-channel FIFO depth in records (power of 2, 2..8).
- CH_W, 2, channel-index width, equal to clog2(N_CH).

Ports:
- clk_rx  in  1  single clock.
- reset_rx  in  1  synchronous, active-high reset.
- ch_enable_i  in  N_CH  per-channel accept mask.
- ch_wr_i  in  N_CH  per-channel record write strobe, one cycle per record.
- ch_kind_i  in  N_CH  record kind per channel: 0 = fast, 1 = serial.
- ch_payload_i  in  N_CH*24  per channel, slice c = [24c+23:24c]. Fast record: {12'h000, data[11:0]}. Serial record: {id[7:0], data[15:0]}.
- out_valid_o  out  1  output record valid.
- out_ready_i  in  1  host accepts the record.
- out_ch_o  out  CH_W  source channel of the output record.
- out_kind_o  out  1  kind of the output record.
- out_payload_o  out  24  payload of the output record.
- ovf_o  out  N_CH  sticky per-channel overflow flag.
- ovf_clr_i  in  N_CH  per-channel overflow clear pulse; also clears that channel's drop counter.
- drop_cnt_o  out  N_CH*8  per-channel saturating drop counter.

Behaviour:
- Clock and reset: one clock, clk_rx. Reset reset_rx is synchronous and active-high.
- Reset values:
  - out_valid_o = 0; out_ch_o, out_kind_o, out_payload_o = 0.
  - ovf_o = 0; drop_cnt_o = 0.
  - All FIFOs empty.
  - Round-robin pointer last = N_CH-1, so channel 0 has first priority.
- Reset asserted mid-operation: all buffered and in-flight records are discarded; no partial output is held.
- Write path:
  - ch_wr_i[c] is honoured only when ch_enable_i[c] = 1; otherwise the write is ignored, with no overflow or count.
  - Deasserting ch_enable_i[c] does not flush FIFO c; stored records still drain.
- Overflow:
  - A write to a full FIFO c is dropped unless FIFO c is popped in the same cycle, in which case it is accepted.
  - A dropped write sets ovf_o[c] and increments drop_cnt[c], saturating at 255.
  - If ovf_clr_i[c] and a drop happen in the same cycle: ovf_o[c] = 1 and drop_cnt[c] = 1 (set wins over clear).
- Output register:
  - "Load-enable" = out_valid_o == 0, or (out_valid_o && out_ready_i).
  - On load-enable: if any FIFO is non-empty, grant channel g, pop FIFO g, and load {g, kind, payload} with out_valid_o = 1. Otherwise out_valid_o <= 0.
  - Round-robin search order is last+1, last+2, … modulo N_CH. On grant, last <= g.
  - While out_valid_o = 1 and out_ready_i = 0, all output signals are held stable and nothing is popped.
- Latency: a write sampled at edge t appears in the FIFO after t. With an idle output it is presented (out_valid_o = 1) after edge t+1, i.e. 2 cycles from strobe to valid.
- Throughput: one record per cycle when out_ready_i is held high.
- Ordering: records from one channel leave in write order. No ordering guarantee across channels.
- FIFO: pointers are CLOG2(DEPTH)+1 bits wide, with wrap-around via the MSB toggle. full/empty are derived from pointer compare. A simultaneous push and pop on an empty FIFO is not a bypass: the push is stored and the pop is not granted, since the FIFO was empty.
- No state machine beyond the output-register valid/hold behaviour; the arbiter pointer is the only scheduling state.

Decomposition:
- Package sent_rx_arb_pkg holds:
  - PAYLOAD_W = 24
  - KIND_FAST = 1'b0, KIND_SERIAL = 1'b1
  - DROP_W = 8
  - Record layout: kind + payload = 25 bits.
- Sub-module sent_rx_ch_fifo: synchronous single-clock FIFO of DEPTH × 25 bits. Interface: push, pop, full, empty, data in, data out. It is instantiated N_CH times.
- Arbiter, output register and counters live in the top level.

Test Plan:
- Single record: reset, then ch_wr_i[2] = 1, kind = 1, payload = 24'hA5_1234 for 1 cycle, out_ready_i = 1 -> two cycles later, out_valid_o = 1 with out_ch_o = 2, out_kind_o = 1, out_payload_o = 24'hA51234, valid for exactly 1 cycle.
- Fairness: all 4 channels write in the same cycle, payloads 24'h00000c (c = channel), ready high -> output order ch0, ch1, ch2, ch3 on consecutive cycles. Then a repeat with ch1 and ch3 only -> ch3 first? No: last = 3, so order is ch1, ch3.
- Backpressure: ready low for 5 cycles with out_valid_o = 1 -> output signals are stable and FIFO occupancy is unchanged. Ready high -> records drain in order with no loss.
- Overflow: ready low, channel 0 writes 4 records with DEPTH = 2 -> out register holds 1, FIFO holds 2, 1 is dropped, so ovf_o[0] = 1 and drop count = 1. Then 300 further drops -> drop count saturates at 255. Then ovf_clr_i[0] -> ovf_o[0] = 0 and drop count = 0.
- Enable and reset: ch_enable_i[1] = 0 with a write on ch1 -> no output and no overflow. Reset asserted while 3 records are buffered -> the next cycle has out_valid_o = 0 and all FIFOs empty.
